// File: rtl/lisnoc_router_output_port_pkg.sv
// rtl/lisnoc_router_output_port_pkg.sv - flit type codes and arbiter state encoding shared by the output port
package lisnoc_router_output_port_pkg;

    // Flit type field, taken from the top two bits of each flit.
    localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_LAST    = 2'b10;
    localparam logic [1:0] FLIT_SINGLE  = 2'b11;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/lisnoc_output_vc_arb.sv
// rtl/lisnoc_output_vc_arb.sv - per-VC round-robin arbiter with wormhole lock
//
// Ports:
//  clk, rst    clock, asynchronous active-low reset
//  request     one request bit per router input port
//  flit_types  type field of each input's current flit, 2 bits per input
//  full        output FIFO of this VC is full, no grant possible
//  grant       one-hot (or zero) acknowledge; the granted flit is written this cycle
module lisnoc_output_vc_arb
    import lisnoc_router_output_port_pkg::*;
#(
    parameter int ports = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ports-1:0]     request,
    input  logic [2*ports-1:0]   flit_types,
    input  logic                 full,
    output logic [ports-1:0]     grant
);

    localparam int PW = (ports > 1) ? $clog2(ports) : 1;

    arb_state_e      state, state_nxt;
    logic [PW-1:0]   owner, owner_nxt;
    logic [PW-1:0]   rr_ptr, rr_nxt;
    logic            found;
    logic [PW-1:0]   pick;
    logic [1:0]      pick_type;
    int              cand;

    always_comb begin
        grant     = '0;
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        found     = 1'b0;
        pick      = '0;
        cand      = 0;

        if (state == ARB_IDLE) begin
            // First requester at or after rr_ptr, wrapping at ports.
            for (int i = 0; i < ports; i++) begin
                cand = int'(rr_ptr) + i;
                if (cand >= ports) cand = cand - ports;
                if (!found && request[cand]) begin
                    found = 1'b1;
                    pick  = PW'(cand);
                end
            end
        end else begin
            // While locked only the packet owner is served.
            found = request[owner];
            pick  = owner;
        end

        pick_type = flit_types[int'(pick)*2 +: 2];

        // Gated with rst so no acknowledge escapes while the port is held in reset.
        if (rst && found && !full) begin
            grant[pick] = 1'b1;
            if (state == ARB_IDLE) begin
                rr_nxt = (int'(pick) == ports - 1) ? '0 : pick + PW'(1);
                // PAYLOAD/LAST arriving in IDLE is a protocol error: accepted, no lock.
                if (pick_type == FLIT_HEADER) begin
                    state_nxt = ARB_LOCKED;
                    owner_nxt = pick;
                end
            end else if (pick_type == FLIT_LAST || pick_type == FLIT_SINGLE) begin
                state_nxt = ARB_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ARB_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
        end
    end

endmodule

// File: rtl/lisnoc_router_output_port.sv
// rtl/lisnoc_router_output_port.sv - router output port: per-VC arbitration, output FIFOs, link mux
//
// Ports:
//  clk, rst        clock, asynchronous active-low reset
//  switch_request  bit [v*ports+p]: input p requests VC v
//  switch_flit     flit of input p for VC v in slice (v*ports+p)
//  switch_read     acknowledge, flit consumed this cycle
//  link_flit       flit on the link, zero when nothing is sent
//  link_valid      one-hot VC of link_flit; every assertion is a completed transfer
//  link_ready      per-VC ready from the downstream input port
module lisnoc_router_output_port
    import lisnoc_router_output_port_pkg::*;
#(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int vchannels       = 1,
    parameter int ports           = 5,
    parameter int fifo_length     = 4
) (
    input  logic                                                      clk,
    input  logic                                                      rst,
    input  logic [ports*vchannels-1:0]                                switch_request,
    input  logic [(flit_data_width+flit_type_width)*ports*vchannels-1:0] switch_flit,
    output logic [ports*vchannels-1:0]                                switch_read,
    output logic [flit_data_width+flit_type_width-1:0]                link_flit,
    output logic [vchannels-1:0]                                      link_valid,
    input  logic [vchannels-1:0]                                      link_ready
);

    localparam int FW = flit_data_width + flit_type_width;
    localparam int AW = (fifo_length > 1) ? $clog2(fifo_length) : 1;
    localparam int CW = $clog2(fifo_length + 1);
    localparam int VW = (vchannels > 1) ? $clog2(vchannels) : 1;

    logic [vchannels-1:0] fifo_full;
    logic [vchannels-1:0] fifo_empty;
    logic [vchannels-1:0] fifo_pop;
    logic [FW-1:0]        fifo_head [vchannels];

    for (genvar v = 0; v < vchannels; v++) begin : g_vc
        logic [ports-1:0]   grant;
        logic [2*ports-1:0] types;
        logic [FW-1:0]      wr_flit;
        logic               push;
        logic [FW-1:0]      mem [fifo_length];
        logic [AW-1:0]      wr_ptr, rd_ptr;
        logic [CW-1:0]      count;

        for (genvar p = 0; p < ports; p++) begin : g_type
            assign types[2*p +: 2] = switch_flit[(v*ports+p)*FW + FW-1 -: 2];
        end

        lisnoc_output_vc_arb #(
            .ports (ports)
        ) u_arb (
            .clk        (clk),
            .rst        (rst),
            .request    (switch_request[v*ports +: ports]),
            .flit_types (types),
            .full       (fifo_full[v]),
            .grant      (grant)
        );

        assign switch_read[v*ports +: ports] = grant;
        assign push = |grant;

        // Grant is one-hot, so an OR of the masked slices selects the winner.
        always_comb begin
            wr_flit = '0;
            for (int p = 0; p < ports; p++) begin
                if (grant[p]) wr_flit = wr_flit | switch_flit[(v*ports+p)*FW +: FW];
            end
        end

        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr] <= wr_flit;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= (int'(wr_ptr) == fifo_length - 1) ? '0 : wr_ptr + AW'(1);
                if (fifo_pop[v])
                    rd_ptr <= (int'(rd_ptr) == fifo_length - 1) ? '0 : rd_ptr + AW'(1);
                if (push && !fifo_pop[v])
                    count <= count + CW'(1);
                else if (!push && fifo_pop[v])
                    count <= count - CW'(1);
            end
        end

        assign fifo_full[v]  = (int'(count) == fifo_length);
        assign fifo_empty[v] = (count == '0);
        assign fifo_head[v]  = mem[rd_ptr];
    end

    logic [VW-1:0] vc_ptr;
    logic [VW-1:0] vc_sel;
    logic          vc_found;
    int            vc_cand;

    always_comb begin
        vc_found  = 1'b0;
        vc_sel    = '0;
        vc_cand   = 0;
        fifo_pop  = '0;
        for (int i = 0; i < vchannels; i++) begin
            vc_cand = int'(vc_ptr) + i;
            if (vc_cand >= vchannels) vc_cand = vc_cand - vchannels;
            if (!vc_found && !fifo_empty[vc_cand] && link_ready[vc_cand]) begin
                vc_found = 1'b1;
                vc_sel   = VW'(vc_cand);
            end
        end
        if (vc_found) fifo_pop[vc_sel] = 1'b1;
    end

    assign link_valid = fifo_pop;
    assign link_flit  = vc_found ? fifo_head[vc_sel] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vc_ptr <= '0;
        end else if (vc_found) begin
            vc_ptr <= (int'(vc_sel) == vchannels - 1) ? '0 : vc_sel + VW'(1);
        end
    end

endmodule

// File: tb/tb_lisnoc_router_output_port.sv
// tb/tb_lisnoc_router_output_port.sv - directed self-checking bench for lisnoc_router_output_port
module tb_lisnoc_router_output_port;

    localparam int FW = 34;
    localparam int P  = 5;
    localparam logic [1:0] T_PAY = 2'b00;
    localparam logic [1:0] T_HDR = 2'b01;
    localparam logic [1:0] T_LST = 2'b10;
    localparam logic [1:0] T_SGL = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [P-1:0]      req_a    = '0;
    logic [FW*P-1:0]   flit_a   = '0;
    logic [P-1:0]      read_a;
    logic [FW-1:0]     lflit_a;
    logic [0:0]        lvalid_a;
    logic [0:0]        lready_a = '0;

    logic [2*P-1:0]    req_b    = '0;
    logic [FW*2*P-1:0] flit_b   = '0;
    logic [2*P-1:0]    read_b;
    logic [FW-1:0]     lflit_b;
    logic [1:0]        lvalid_b;
    logic [1:0]        lready_b = '0;

    int vectors     = 0;
    int miscompares = 0;

    lisnoc_router_output_port #(
        .flit_data_width(32), .flit_type_width(2), .vchannels(1), .ports(P), .fifo_length(4)
    ) dut_a (
        .clk(clk), .rst(rst), .switch_request(req_a), .switch_flit(flit_a), .switch_read(read_a),
        .link_flit(lflit_a), .link_valid(lvalid_a), .link_ready(lready_a)
    );

    lisnoc_router_output_port #(
        .flit_data_width(32), .flit_type_width(2), .vchannels(2), .ports(P), .fifo_length(4)
    ) dut_b (
        .clk(clk), .rst(rst), .switch_request(req_b), .switch_flit(flit_b), .switch_read(read_b),
        .link_flit(lflit_b), .link_valid(lvalid_b), .link_ready(lready_b)
    );

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] d);
        return {t, d};
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int p, input logic [1:0] t, input logic [31:0] d);
        flit_a[p*FW +: FW] = mk(t, d);
    endtask

    task automatic set_b(input int slot, input logic [1:0] t, input logic [31:0] d);
        flit_b[slot*FW +: FW] = mk(t, d);
    endtask

    task automatic apply_reset;
        rst = 1'b0;
        req_a = '0; flit_a = '0; lready_a = '0;
        req_b = '0; flit_b = '0; lready_b = '0;
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        req_a = '1; lready_a = 1'b1;
        req_b = '1; lready_b = 2'b11;
        for (int p = 0; p < P; p++) set_a(p, T_SGL, 32'h10 + p);
        next_cycle();
        @(negedge clk);
        vectors++; if (read_a !== 5'b00000) begin miscompares++; $display("FAIL rst_read_a got=%b exp=%b", read_a, 5'b00000); end
        vectors++; if (lvalid_a !== 1'b0) begin miscompares++; $display("FAIL rst_valid_a got=%b exp=0", lvalid_a); end
        vectors++; if (lflit_a !== '0) begin miscompares++; $display("FAIL rst_flit_a got=%h exp=0", lflit_a); end
        vectors++; if (read_b !== 10'b0) begin miscompares++; $display("FAIL rst_read_b got=%b exp=0", read_b); end
        vectors++; if (lvalid_b !== 2'b00) begin miscompares++; $display("FAIL rst_valid_b got=%b exp=00", lvalid_b); end
        next_cycle();
        rst = 1'b1; req_b = '0;
        @(negedge clk);
        vectors++; if (read_a !== 5'b00001) begin miscompares++; $display("FAIL rst_first_grant got=%b exp=%b", read_a, 5'b00001); end
        vectors++; if (lvalid_a !== 1'b0) begin miscompares++; $display("FAIL rst_first_valid got=%b exp=0", lvalid_a); end
        next_cycle();
        @(negedge clk);
        vectors++; if (read_a !== 5'b00010) begin miscompares++; $display("FAIL rst_second_grant got=%b exp=%b", read_a, 5'b00010); end
        vectors++; if (lvalid_a !== 1'b1 || lflit_a !== mk(T_SGL, 32'h10)) begin miscompares++; $display("FAIL rst_first_link got=%b/%h exp=1/%h", lvalid_a, lflit_a, mk(T_SGL, 32'h10)); end
        next_cycle();
    endtask

    task automatic test_wormhole;
        logic [4:0]    rq [6];
        logic [4:0]    er [6];
        logic          ev [6];
        logic [FW-1:0] ef [6];
        rq = '{5'b00100, 5'b00110, 5'b00110, 5'b00010, 5'b00000, 5'b00000};
        er = '{5'b00100, 5'b00100, 5'b00100, 5'b00010, 5'b00000, 5'b00000};
        ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ef = '{'0, mk(T_HDR, 32'hA0), mk(T_PAY, 32'hA1), mk(T_LST, 32'hA2), mk(T_SGL, 32'hB0), '0};
        apply_reset();
        lready_a = 1'b1;
        set_a(1, T_SGL, 32'hB0);
        for (int c = 0; c < 6; c++) begin
            req_a = rq[c];
            if (c < 3) set_a(2, (c == 0) ? T_HDR : (c == 1) ? T_PAY : T_LST, 32'hA0 + c);
            @(negedge clk);
            vectors++; if (read_a !== er[c]) begin miscompares++; $display("FAIL wormhole_read c%0d got=%b exp=%b", c, read_a, er[c]); end
            vectors++; if (lvalid_a !== ev[c]) begin miscompares++; $display("FAIL wormhole_valid c%0d got=%b exp=%b", c, lvalid_a, ev[c]); end
            vectors++; if (lflit_a !== ef[c]) begin miscompares++; $display("FAIL wormhole_flit c%0d got=%h exp=%h", c, lflit_a, ef[c]); end
            next_cycle();
        end
    endtask

    task automatic test_round_robin;
        int ord [3];
        logic [4:0] exp_r;
        ord = '{0, 3, 4};
        apply_reset();
        lready_a = 1'b1;
        req_a = 5'b11001;
        set_a(0, T_SGL, 32'h100); set_a(3, T_SGL, 32'h103); set_a(4, T_SGL, 32'h104);
        for (int c = 0; c < 8; c++) begin
            if (c == 6) req_a = '0;
            @(negedge clk);
            exp_r = (c < 6) ? (5'b00001 << ord[c % 3]) : 5'b00000;
            vectors++; if (read_a !== exp_r) begin miscompares++; $display("FAIL rr_read c%0d got=%b exp=%b", c, read_a, exp_r); end
            if (c >= 1 && c <= 6) begin
                vectors++;
                if (lvalid_a !== 1'b1 || lflit_a !== mk(T_SGL, 32'h100 + ord[(c-1) % 3])) begin
                    miscompares++;
                    $display("FAIL rr_link c%0d got=%b/%h exp=1/%h", c, lvalid_a, lflit_a, mk(T_SGL, 32'h100 + ord[(c-1) % 3]));
                end
            end else begin
                vectors++; if (lvalid_a !== 1'b0) begin miscompares++; $display("FAIL rr_idle c%0d got=%b exp=0", c, lvalid_a); end
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure;
        int k;
        k = 0;
        apply_reset();
        lready_a = 1'b0;
        req_a = 5'b00001;
        for (int c = 0; c < 6; c++) begin
            set_a(0, T_SGL, 32'h200 + k);
            @(negedge clk);
            vectors++; if (read_a !== ((c < 4) ? 5'b00001 : 5'b00000)) begin miscompares++; $display("FAIL bp_fill_read c%0d got=%b exp=%b", c, read_a, (c < 4) ? 5'b00001 : 5'b00000); end
            vectors++; if (lvalid_a !== 1'b0) begin miscompares++; $display("FAIL bp_fill_valid c%0d got=%b exp=0", c, lvalid_a); end
            if (read_a[0]) k++;
            next_cycle();
        end
        vectors++; if (k !== 4) begin miscompares++; $display("FAIL bp_accepted got=%0d exp=4", k); end
        set_a(0, T_SGL, 32'h204);
        lready_a = 1'b1;
        @(negedge clk);
        vectors++; if (read_a !== 5'b00000) begin miscompares++; $display("FAIL bp_full_pop_read got=%b exp=00000", read_a); end
        vectors++; if (lvalid_a !== 1'b1 || lflit_a !== mk(T_SGL, 32'h200)) begin miscompares++; $display("FAIL bp_drain0 got=%b/%h exp=1/%h", lvalid_a, lflit_a, mk(T_SGL, 32'h200)); end
        next_cycle();
        req_a = '0;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                vectors++; if (lvalid_a !== 1'b1 || lflit_a !== mk(T_SGL, 32'h200 + i)) begin miscompares++; $display("FAIL bp_drain%0d got=%b/%h exp=1/%h", i, lvalid_a, lflit_a, mk(T_SGL, 32'h200 + i)); end
            end else begin
                vectors++; if (lvalid_a !== 1'b0) begin miscompares++; $display("FAIL bp_empty got=%b exp=0", lvalid_a); end
            end
            next_cycle();
        end
    endtask

    task automatic fill_b(input logic [31:0] base0, input logic [31:0] base1);
        lready_b = 2'b00;
        req_b = 10'b0000100001;
        for (int k = 0; k < 2; k++) begin
            set_b(0, T_SGL, base0 + k);
            set_b(5, T_SGL, base1 + k);
            @(negedge clk);
            vectors++; if (read_b !== 10'b0000100001) begin miscompares++; $display("FAIL vc_fill_read k%0d got=%b exp=%b", k, read_b, 10'b0000100001); end
            next_cycle();
        end
        req_b = '0;
    endtask

    task automatic test_vc_interleave;
        logic [1:0]    ev [5];
        logic [FW-1:0] ef [5];
        apply_reset();
        fill_b(32'h300, 32'h400);
        ev = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        ef = '{mk(T_SGL, 32'h300), mk(T_SGL, 32'h400), mk(T_SGL, 32'h301), mk(T_SGL, 32'h401), '0};
        lready_b = 2'b11;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++; if (lvalid_b !== ev[c] || lflit_b !== ef[c]) begin miscompares++; $display("FAIL vc_alt c%0d got=%b/%h exp=%b/%h", c, lvalid_b, lflit_b, ev[c], ef[c]); end
            next_cycle();
        end
        fill_b(32'h310, 32'h410);
        ev = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
        ef = '{mk(T_SGL, 32'h410), mk(T_SGL, 32'h411), '0, '0, '0};
        lready_b = 2'b10;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if (lvalid_b !== ev[c] || lflit_b !== ef[c]) begin miscompares++; $display("FAIL vc_only1 c%0d got=%b/%h exp=%b/%h", c, lvalid_b, lflit_b, ev[c], ef[c]); end
            next_cycle();
        end
        ev = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
        ef = '{mk(T_SGL, 32'h310), mk(T_SGL, 32'h311), '0, '0, '0};
        lready_b = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if (lvalid_b !== ev[c] || lflit_b !== ef[c]) begin miscompares++; $display("FAIL vc_rest0 c%0d got=%b/%h exp=%b/%h", c, lvalid_b, lflit_b, ev[c], ef[c]); end
            next_cycle();
        end
    endtask

    task automatic test_mid_packet_reset;
        apply_reset();
        lready_a = 1'b0;
        req_a = 5'b01000;
        set_a(3, T_HDR, 32'h500);
        @(negedge clk);
        vectors++; if (read_a !== 5'b01000) begin miscompares++; $display("FAIL mpr_header got=%b exp=%b", read_a, 5'b01000); end
        next_cycle();
        req_a = '0;
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (read_a !== 5'b00000 || lvalid_a !== 1'b0) begin miscompares++; $display("FAIL mpr_in_reset got=%b/%b exp=00000/0", read_a, lvalid_a); end
        next_cycle();
        rst = 1'b1;
        lready_a = 1'b1;
        @(negedge clk);
        vectors++; if (lvalid_a !== 1'b0) begin miscompares++; $display("FAIL mpr_fifo_empty got=%b/%h exp=0", lvalid_a, lflit_a); end
        next_cycle();
        req_a = 5'b01010;
        set_a(1, T_SGL, 32'h502);
        set_a(3, T_SGL, 32'h501);
        @(negedge clk);
        vectors++; if (read_a !== 5'b00010) begin miscompares++; $display("FAIL mpr_idle_grant got=%b exp=%b", read_a, 5'b00010); end
        next_cycle();
        req_a = 5'b01000;
        @(negedge clk);
        vectors++; if (read_a !== 5'b01000) begin miscompares++; $display("FAIL mpr_grant3 got=%b exp=%b", read_a, 5'b01000); end
        vectors++; if (lvalid_a !== 1'b1 || lflit_a !== mk(T_SGL, 32'h502)) begin miscompares++; $display("FAIL mpr_link0 got=%b/%h exp=1/%h", lvalid_a, lflit_a, mk(T_SGL, 32'h502)); end
        next_cycle();
        req_a = '0;
        @(negedge clk);
        vectors++; if (lvalid_a !== 1'b1 || lflit_a !== mk(T_SGL, 32'h501)) begin miscompares++; $display("FAIL mpr_link1 got=%b/%h exp=1/%h", lvalid_a, lflit_a, mk(T_SGL, 32'h501)); end
        next_cycle();
    endtask

    initial begin
        next_cycle();
        test_reset();
        test_wormhole();
        test_round_robin();
        test_backpressure();
        test_vc_interleave();
        test_mid_packet_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
